// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch and PC-update stage with req/ack instruction memory port
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [31:0]       NOP_WORD = 32'hE1A00000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              PCSrc,
    input  logic              bx,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] bx_target,
    input  logic              advance,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ack,
    output logic [31:0]       instruction,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus8,
    output logic [31:0]       retired
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, next_pc;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       retired_q, retired_d;
    logic              valid_q, valid_d;

    // Targets are word aligned; the low bits (incl. the Thumb bit of BX) are dropped.
    logic unused_target_bits;
    assign unused_target_bits = ^{branch_target[1:0], bx_target[1:0]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_WORD;
            valid_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        next_pc = pc_q + ADDR_W'(4);
        if (PCSrc) begin
            if (bx) begin
                next_pc = {bx_target[ADDR_W-1:2], 2'b00};
            end else begin
                next_pc = {branch_target[ADDR_W-1:2], 2'b00};
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        retired_d = retired_q;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (advance) begin
                    instr_d   = NOP_WORD;
                    valid_d   = 1'b0;
                    retired_d = retired_q + 32'd1;
                    pc_d      = next_pc;
                    state_d   = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus8    = pc_q + ADDR_W'(8);
    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign retired     = retired_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch and PC-update stage directly upstream of the controller.
- Holds the PC and fetches one instruction word over a req/ack instruction-memory interface.
- Presents the word on `instruction` until the datapath retires it.
- On retire, selects the next PC from the controller's `PCSrc`/`bx` decisions: sequential, branch target, or BX register target.

Parameters:
- ADDR_W, 32, width of PC and instruction-memory address.
- RESET_PC, 0, PC value loaded on reset.
- NOP_WORD, 32'hE1A00000, word driven on `instruction` while no valid word is held (MOV r0,r0, cond=AL).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- PCSrc  in  1  from controller: take a branch for the held instruction.
- bx  in  1  from controller: branch is BX (register target).
- branch_target  in  ADDR_W  ALU result (PC+8+imm) for B/BL.
- bx_target  in  ADDR_W  Rm value for BX.
- advance  in  1  datapath has completed the held instruction this cycle.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address, equal to pc.
- imem_rdata  in  32  fetched word, valid when imem_ack=1.
- imem_ack  in  1  memory returns data this cycle.
- instruction  out  32  instruction to the controller/datapath.
- instr_valid  out  1  `instruction` holds a fetched word.
- pc  out  ADDR_W  address of the held instruction.
- pc_plus8  out  ADDR_W  pc+8, the R15 read value; combinational, modulo 2^ADDR_W.
- retired  out  32  count of retired instructions.

Behaviour:
- Reset (async, while reset_n=0):
  - State IDLE; pc=RESET_PC; imem_req=0; instr_valid=0; instruction=NOP_WORD; retired=0.
  - All outputs take reset values immediately, without waiting for a clock edge.
- States:
  - IDLE: first edge after reset release → REQ.
  - REQ:
    - imem_req=1, imem_addr=pc.
    - On an edge with imem_ack=1: instruction←imem_rdata, instr_valid←1 → HOLD.
    - Otherwise remain in REQ; req stays high and the address stays stable.
  - HOLD:
    - imem_req=0; instruction and pc stay stable.
    - On an edge with advance=1:
      - instr_valid←0, instruction←NOP_WORD, retired←retired+1.
      - pc←next_pc (below) → REQ.
- next_pc, evaluated in the advance cycle:
  - PCSrc=1 and bx=1: {bx_target[ADDR_W-1:2],2'b00}; bit0 (Thumb) is ignored.
  - PCSrc=1 and bx=0: {branch_target[ADDR_W-1:2],2'b00}.
  - PCSrc=0: pc+4. bx alone, with PCSrc=0, has no effect.
- Arithmetic:
  - pc+4 and pc+8 are modulo 2^ADDR_W; 0xFFFFFFFC+4 → 0x00000000.
  - retired wraps 0xFFFFFFFF → 0.
- Latency:
  - Ack may arrive in the same cycle as req, giving a zero-wait fetch.
  - Minimum two cycles per instruction: one REQ cycle plus one HOLD cycle.
  - Fetch-to-valid latency is 1 edge after ack.
- Ignored inputs:
  - advance outside HOLD is ignored; no count, no PC change.
  - PCSrc/bx/targets are ignored unless advance=1 in HOLD.
  - imem_ack outside REQ is ignored, including stale acks after reset.
- Reset mid-request: req drops asynchronously and the PC returns to RESET_PC; any ack already in flight is discarded.

Test Plan:
- Reset with RESET_PC=0x100; release; imem_ack=1 immediately with rdata=0xE0810002 → imem_addr=0x100; instr_valid=1 on the next edge; instruction=0xE0810002; pc_plus8=0x108.
- Hold ack low for 3 cycles in REQ → imem_req stays 1 and imem_addr stays fixed throughout; instr_valid stays 0; instruction=0xE1A00000.
- In HOLD at pc=0x200, advance=1, PCSrc=1, bx=0, branch_target=0x40A → pc=0x408, next imem_addr=0x408, retired increments by 1.
- In HOLD, advance=1, PCSrc=1, bx=1, bx_target=0x00000301 → pc=0x300. With PCSrc=0, bx=1 → pc=old pc+4.
- At pc=0xFFFFFFFC, advance=1, PCSrc=0 → pc=0x00000000, pc_plus8 while held=0x00000004. advance pulsed in REQ → no pc/retired change.
- Assert reset_n=0 mid-REQ, then ack=1 during reset → imem_req=0 immediately, pc=RESET_PC, ack ignored, retired=0.
